// File: rtl/tap_acc.sv
// Frame accumulator: sums N_TERMS signed samples with sticky signed-overflow flag,
// then holds the result until taken. Define TAP_ACC_SAT_EN for saturating adds (default wraps).
module tap_acc #(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 15,
  parameter int N_TERMS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_res,
  output logic             o_ovr
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  localparam logic ST_ACC  = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  // FRAC only documents the number format; it never affects arithmetic.
  if (FRAC >= WIDTH || N_TERMS < 1 || N_TERMS > 256) begin : g_bad_cfg
    $error("tap_acc: illegal parameter combination");
  end

  logic             state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic             sticky_q;

  logic             accept;
  logic             first;
  logic             last;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic [WIDTH-1:0] acc_d;
  logic             sticky_d;

  assign o_ready = (state_q == ST_ACC);
  assign o_valid = (state_q == ST_HOLD);

  assign accept = i_valid && o_ready;
  assign first  = (cnt_q == '0);
  assign last   = (cnt_q == LAST_CNT);
  assign sum    = acc_q + i_data;

  // Same-sign addends producing a different-sign sum; the first sample of a
  // frame is a load, not an add, so it can never overflow.
  assign ovf = !first && (acc_q[WIDTH-1] == i_data[WIDTH-1]) &&
               (sum[WIDTH-1] != acc_q[WIDTH-1]);

  always_comb begin
    acc_d    = sum;
    sticky_d = sticky_q | ovf;
    if (first) begin
      acc_d    = i_data;
      sticky_d = 1'b0;
    end
`ifdef TAP_ACC_SAT_EN
    else if (ovf) begin
      // Clamp toward the sign of the (shared) addend sign.
      acc_d = acc_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_ACC;
      cnt_q    <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      o_res    <= '0;
      o_ovr    <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept) begin
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            if (last) begin
              cnt_q   <= '0;
              o_res   <= acc_d;
              o_ovr   <= sticky_d;
              state_q <= ST_HOLD;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          if (i_ready) state_q <= ST_ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tap_acc.sv
// Directed bench for tap_acc at WIDTH=16, N_TERMS=4; expectations follow TAP_ACC_SAT_EN.
module tb_tap_acc;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_data;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_res;
  logic        o_ovr;

  int n_vec = 0;
  int n_bad = 0;

  tap_acc #(.WIDTH(16), .FRAC(15), .N_TERMS(4)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data (i_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_res  (o_res),
    .o_ovr  (o_ovr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string            name;
    logic [3:0][15:0] d;      // time order: d[3] first ... d[0] last
    logic [15:0]      exp_res;
    logic             exp_ovr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Back-to-back frame, then checks latency and the held result.
  task automatic run_frame(input string nm, input logic [3:0][15:0] d,
                           input logic [15:0] er, input logic eo);
    for (int k = 3; k >= 0; k--) begin
      i_valid = 1'b1;
      i_data  = d[k];
      tick();
      if (k == 1) chk({nm, ".valid_early"}, 16'(o_valid), 16'd0);
    end
    i_valid = 1'b0;
    chk({nm, ".valid"}, 16'(o_valid), 16'd1);
    chk({nm, ".ready"}, 16'(o_ready), 16'd0);
    chk({nm, ".res"},   o_res, er);
    chk({nm, ".ovr"},   16'(o_ovr), 16'(eo));
  endtask

  task automatic release_hold();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"ramp1000", {16'h1000, 16'h1000, 16'h1000, 16'h1000}, 16'h4000, 1'b0};
`ifdef TAP_ACC_SAT_EN
    vecs[1] = '{"pos_ovf", {16'h4000, 16'h4000, 16'h4000, 16'h4000}, 16'h7FFF, 1'b1};
    vecs[2] = '{"neg_ovf", {16'hC000, 16'hC000, 16'hC000, 16'hC000}, 16'h8000, 1'b1};
    vecs[3] = '{"mixed",   {16'h7000, 16'h7000, 16'h9000, 16'h0000}, 16'h0FFF, 1'b1};
    vecs[5] = '{"minmin",  {16'h8000, 16'h8000, 16'h0000, 16'h0001}, 16'h8001, 1'b1};
`else
    vecs[1] = '{"pos_ovf", {16'h4000, 16'h4000, 16'h4000, 16'h4000}, 16'h0000, 1'b1};
    vecs[2] = '{"neg_ovf", {16'hC000, 16'hC000, 16'hC000, 16'hC000}, 16'h0000, 1'b1};
    vecs[3] = '{"mixed",   {16'h7000, 16'h7000, 16'h9000, 16'h0000}, 16'h7000, 1'b1};
    vecs[5] = '{"minmin",  {16'h8000, 16'h8000, 16'h0000, 16'h0001}, 16'h0001, 1'b1};
`endif
    vecs[4] = '{"no_ovf_x", {16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF}, 16'hFFFF, 1'b0};
    vecs[6] = '{"sticky_clr", {16'h0100, 16'h0200, 16'h0300, 16'h0400}, 16'h0A00, 1'b0};

    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_ready = 1'b0;
    tick(); tick();
    chk("rst.res",   o_res, 16'h0000);
    chk("rst.ovr",   16'(o_ovr), 16'd0);
    chk("rst.valid", 16'(o_valid), 16'd0);
    chk("rst.ready", 16'(o_ready), 16'd1);
    i_rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_frame(vecs[i].name, vecs[i].d, vecs[i].exp_res, vecs[i].exp_ovr);
      release_hold();
      chk({vecs[i].name, ".ready_after"}, 16'(o_ready), 16'd1);
    end

    // Backpressure: samples offered during HOLD must not be consumed.
    run_frame("bp", {16'h1000, 16'h1000, 16'h1000, 16'h1000}, 16'h4000, 1'b0);
    i_valid = 1'b1; i_data = 16'h2222;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp.hold_res",   o_res, 16'h4000);
      chk("bp.hold_ready", 16'(o_ready), 16'd0);
      chk("bp.hold_valid", 16'(o_valid), 16'd1);
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("bp.exit_valid", 16'(o_valid), 16'd0);
    i_data = 16'h0010;
    tick(); tick();
    chk("bp.res_kept", o_res, 16'h4000);
    tick(); tick();
    i_valid = 1'b0;
    chk("bp.next_valid", 16'(o_valid), 16'd1);
    chk("bp.next_res",   o_res, 16'h0040);
    release_hold();

    // Reset mid-frame, then a frame with i_valid gaps.
    i_valid = 1'b1; i_data = 16'h1234;
    tick(); tick();
    i_valid = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    chk("midrst.res",   o_res, 16'h0000);
    chk("midrst.valid", 16'(o_valid), 16'd0);
    tick();
    i_rst = 1'b0;
    tick();
    i_data = 16'h0100;
    for (int c = 0; c < 8; c++) begin
      i_valid = (c % 2 == 0);
      tick();
      if (c < 6) chk("gap.valid_low", 16'(o_valid), 16'd0);
    end
    i_valid = 1'b0;
    chk("gap.valid", 16'(o_valid), 16'd1);
    chk("gap.res",   o_res, 16'h0400);
    chk("gap.ovr",   16'(o_ovr), 16'd0);

    // Reset while holding discards the pending result.
    #2 i_rst = 1'b1;
    #1;
    chk("holdrst.valid", 16'(o_valid), 16'd0);
    chk("holdrst.res",   o_res, 16'h0000);
    chk("holdrst.ready", 16'(o_ready), 16'd1);
    tick();
    i_rst = 1'b0;
    tick();
    run_frame("postrst", {16'h0003, 16'hFFFF, 16'h0002, 16'h0005}, 16'h0009, 1'b0);
    release_hold();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
